// File: rtl/ram_nibble_pkg.sv
// Shared types and sizes for the nibble read sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_nibble_pkg;

  parameter int NIB_W     = 4;   // nibble width (RAM word width / 2)
  parameter int ADDR_W    = 5;   // nibble address width (RAM word address bits + 1)
  parameter int BUF_DEPTH = 2;   // output buffer entries; also the issue credit limit

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ram_nibble_reader_fifo.sv
// Two-entry synchronous FIFO holding captured nibbles; head is visible combinationally.
// Latency: a push is visible at o_head on the cycle after the pushing edge.
// Backpressure: the caller's credit scheme keeps it from overflowing; a lossy push is flagged.
module nibble_fifo2
  import ram_nibble_pkg::*;
#(
  parameter int W = NIB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_full;
  logic         w_pop;
  logic         w_push;

  assign w_full  = (r_count == 2'(BUF_DEPTH));
  assign w_pop   = i_pop && (r_count != 2'd0);
  // A push into a full buffer is only lossless if the head leaves on the same edge.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && w_full && !w_pop));

endmodule

// File: rtl/ram_nibble_reader.sv
// Walks a run of nibble addresses, one RAM read per cycle, and streams the nibbles out in order.
// Latency: start at edge 0, first read at edge 1, first out_valid after edge 2; 1 nibble/cycle.
// Backpressure: reads stop issuing once buffered + in-flight nibbles would exceed 2.
module ram_nibble_reader
  import ram_nibble_pkg::*;
#(
  parameter int DEPTH = ADDR_W - 1,
  parameter int WIDTH = 2 * NIB_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [DEPTH:0]     start_addr,
  input  logic [DEPTH+1:0]   count,
  output logic [DEPTH:0]     readAddr,
  input  logic [WIDTH/2-1:0] ram_dout,
  output logic [WIDTH/2-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int AW = DEPTH + 1;
  localparam int CW = DEPTH + 2;
  localparam int NW = WIDTH / 2;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_remaining;
  logic          r_inflight;

  logic [1:0]    w_buf_count;
  logic [NW-1:0] w_head;
  logic          w_pop;
  logic [2:0]    w_occ;
  logic [2:0]    w_lim;
  logic          w_rd_issue;
  logic          w_load;

  assign w_pop = out_valid & out_ready;

  // Occupancy counts the nibble still coming back from the RAM, so a pop this
  // cycle frees exactly one credit for a new read.
  assign w_occ      = {1'b0, w_buf_count} + {2'b00, r_inflight};
  assign w_lim      = 3'(BUF_DEPTH) + {2'b00, w_pop};
  assign w_rd_issue = (r_state == RUN) && (r_remaining != '0) && (w_occ < w_lim);
  assign w_load     = (r_state == IDLE) && start && (count != '0);

  assign readAddr  = r_addr;
  assign out_data  = w_head;
  assign out_valid = (w_buf_count != 2'd0);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus busy/done decode.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (count != '0) ? RUN : FINISH;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_rd_issue && (r_remaining == CW'(1))) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!r_inflight && (w_buf_count == 2'd0) && !w_pop) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address walk, remaining count and the one-cycle read-latency tracker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_rd_issue;
      if (w_load) begin
        r_addr      <= start_addr;
        r_remaining <= count;
      end else if (w_rd_issue) begin
        r_addr      <= r_addr + AW'(1);
        r_remaining <= r_remaining - CW'(1);
      end
    end
  end

  // The RAM data for a read issued last edge is captured here.
  nibble_fifo2 #(
    .W (NW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (ram_dout),
    .o_head  (w_head),
    .o_count (w_buf_count)
  );

endmodule

// File: tb/tb_ram_nibble_reader.sv
// Self-checking bench for ram_nibble_reader with a registered-read RAM model and a scoreboard.
// Latency: n/a.
// Backpressure: out_ready is driven from per-command patterns.
module tb_ram_nibble_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [4:0] start_addr;
  logic [5:0] count;
  logic [4:0] readAddr;
  logic [3:0] ram_dout = 4'h0;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  ram_nibble_reader #(.DEPTH(4), .WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .readAddr   (readAddr),
    .ram_dout   (ram_dout),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  // RAM model: registered read, even nibble address -> upper nibble.
  logic [7:0] mem [16];
  always @(posedge clk) ram_dout <= readAddr[0] ? mem[readAddr[4:1]][3:0] : mem[readAddr[4:1]][7:4];

  function automatic logic [3:0] nib(input logic [4:0] a);
    logic [7:0] w;
    w = mem[a[4:1]];
    return a[0] ? w[3:0] : w[7:4];
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [3:0] exp_q[$];
  logic [4:0] addr_log[$];
  int         issues = 0;
  int         pops = 0;
  int         dn_cnt = 0;
  bit         mon_en = 0;
  logic [4:0] last_addr;
  bit         prev_stall = 0;
  logic [3:0] prev_data;
  logic [3:0] first_pop;

  // Monitor: issue tracking, credit bound, stall stability and scoreboard pops.
  always @(negedge clk) begin
    if (done) dn_cnt++;
    if (mon_en) begin
      if (readAddr != last_addr) begin
        addr_log.push_back(last_addr);
        issues++;
        last_addr = readAddr;
      end
      chk("occupancy_le_2", (issues - pops) <= 2, 1);
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_data_held", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        chk("stream_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("stream_data", out_data, exp_q.pop_front());
        end
        if (pops == 0) first_pop = out_data;
        pops++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [4:0] a, input logic [5:0] c, input logic rdy0);
    logic [4:0] na;
    for (int k = 0; k < int'(c); k++) begin
      na = a + 5'(k);
      exp_q.push_back(nib(na));
    end
    addr_log.delete();
    issues     = 0;
    pops       = 0;
    prev_stall = 0;
    start_addr = a;
    count      = c;
    start      = 1'b1;
    out_ready  = rdy0;
    step();
    start     = 1'b0;
    last_addr = readAddr;
    mon_en    = 1;
  endtask

  task automatic finish_cmd(input logic [4:0] a, input logic [5:0] c, input logic [15:0] pat,
                            input int budget, output int cyc);
    logic [4:0] ea;
    cyc = 0;
    while (!done && cyc < budget) begin
      out_ready = pat[(cyc + 1) % 16];
      step();
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("busy_low_at_done", busy, 0);
    mon_en = 0;
    out_ready = 1'b1;
    step();
    chk("done_single_pulse", done, 0);
    chk("all_delivered", exp_q.size(), 0);
    chk("issue_count", issues, c);
    for (int k = 0; k < addr_log.size(); k++) begin
      ea = a + 5'(k);
      chk("read_addr_seq", addr_log[k], ea);
    end
    exp_q.delete();
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [5:0]  cnt;
    logic [15:0] pat;
    logic [3:0]  first;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int cyc;
    int dn_snap;
    int k;

    for (int i = 0; i < 16; i++) mem[i] = {4'(i), ~4'(i)};
    mem[0]  = 8'hA5;
    mem[1]  = 8'h3C;
    mem[15] = 8'h71;

    tbl[0] = '{addr: 5'd30, cnt: 6'd4,  pat: 16'hFFFF, first: 4'h7};
    tbl[1] = '{addr: 5'd2,  cnt: 6'd6,  pat: 16'h9A69, first: 4'h3};
    tbl[2] = '{addr: 5'd10, cnt: 6'd32, pat: 16'hB5D3, first: 4'h5};
    tbl[3] = '{addr: 5'd31, cnt: 6'd1,  pat: 16'h0F0F, first: 4'h1};

    reset_n    = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    out_ready  = 1'b1;
    #2;
    chk("rst_readAddr", readAddr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Basic run with exact cycle timing.
    start_cmd(5'd0, 6'd4, 1'b1);
    chk("basic_busy_e0", busy, 1);
    chk("basic_valid_e0", out_valid, 0);
    step();
    chk("basic_valid_e1", out_valid, 0);
    step();
    chk("basic_valid_e2", out_valid, 1);
    chk("basic_data_0", out_data, 4'hA);
    step();
    chk("basic_data_1", out_data, 4'h5);
    step();
    chk("basic_data_2", out_data, 4'h3);
    step();
    chk("basic_data_3", out_data, 4'hC);
    finish_cmd(5'd0, 6'd4, 16'hFFFF, 20, cyc);
    chk("basic_done_timing", cyc, 2);

    // Table: wrap, backpressure, full-length run, single nibble.
    for (int i = 0; i < 4; i++) begin
      start_cmd(tbl[i].addr, tbl[i].cnt, tbl[i].pat[0]);
      finish_cmd(tbl[i].addr, tbl[i].cnt, tbl[i].pat, 400, cyc);
      chk("tbl_first_nibble", first_pop, tbl[i].first);
    end

    // count == 0: nothing issued, done follows promptly.
    dn_snap = dn_cnt;
    start_cmd(5'd7, 6'd0, 1'b1);
    finish_cmd(5'd7, 6'd0, 16'hFFFF, 3, cyc);
    chk("cnt0_no_valid", out_valid, 0);
    chk("cnt0_addr_untouched", readAddr, 5'd0);
    chk("cnt0_done_once", dn_cnt - dn_snap, 1);

    // Start while busy is ignored.
    start_cmd(5'd8, 6'd8, 1'b1);
    step();
    step();
    start_addr = 5'd20;
    count      = 6'd3;
    start      = 1'b1;
    step();
    start = 1'b0;
    finish_cmd(5'd8, 6'd8, 16'hFFFF, 100, cyc);
    mon_en = 1;
    for (int j = 0; j < 6; j++) step();
    mon_en = 0;
    chk("busy_start_ignored_valid", out_valid, 0);
    chk("busy_start_ignored_addr", readAddr, 5'd16);
    chk("busy_start_ignored_pops", pops, 8);

    // Reset in the middle of a run.
    start_cmd(5'd0, 6'd8, 1'b1);
    k = 0;
    while (pops < 2 && k < 20) begin
      step();
      k++;
    end
    chk("mid_reset_reached", pops >= 2, 1);
    dn_snap = dn_cnt;
    reset_n = 1'b0;
    #1;
    mon_en = 0;
    chk("mid_rst_readAddr", readAddr, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    step();
    step();
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) step();
    chk("mid_rst_no_done", dn_cnt - dn_snap, 0);
    chk("mid_rst_idle_busy", busy, 0);
    start_cmd(5'd4, 6'd2, 1'b1);
    finish_cmd(5'd4, 6'd2, 16'hFFFF, 20, cyc);
    chk("post_rst_first", first_pop, nib(5'd4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
